// File: rtl/vga_sync_decoder.sv
// VGA timing decoder: recovers the raster position from free-running hsync/vsync,
// qualifies the timing over several frames before declaring lock, and then emits
// one registered pixel per active-window sample with its x/y coordinate.
module vga_sync_decoder #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    input  logic        err_clr,
    output logic        pixel_valid,
    output logic [11:0] pixel_data,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_PULSE  = 10'(H_SYNC);
    localparam logic [9:0] V_PULSE  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    localparam int              CNT_W     = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [9:0]       hc_q, hc_d;
    logic [9:0]       vc_q, vc_d;
    logic             hs_prev_q, hs_prev_d;
    logic             vs_line_q, vs_line_d;
    logic             h_err_q, h_err_d;
    logic             v_err_q, v_err_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic [11:0]      pixel_data_q, pixel_data_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic             frame_start_q, frame_start_d;

    logic h_fall, h_rise, v_fall, v_rise;
    logic h_evt, v_evt, err_evt, active;

    function automatic logic [9:0] sat_inc(input logic [9:0] val);
        return (val == 10'h3FF) ? val : val + 10'd1;
    endfunction

    // Edge detection and raster counters; everything advances only on pixel strobes.
    always_comb begin
        hc_d      = hc_q;
        vc_d      = vc_q;
        hs_prev_d = hs_prev_q;
        vs_line_d = vs_line_q;
        h_fall    = 1'b0;
        h_rise    = 1'b0;
        v_fall    = 1'b0;
        v_rise    = 1'b0;
        if (pix_en) begin
            h_fall    = !h_sync_in && hs_prev_q;
            h_rise    = h_sync_in && !hs_prev_q;
            hs_prev_d = h_sync_in;
            hc_d      = h_fall ? 10'd0 : sat_inc(hc_q);
            // vsync is only looked at once per line, on the hsync falling edge
            if (h_fall) begin
                v_fall    = !v_sync_in && vs_line_q;
                v_rise    = v_sync_in && !vs_line_q;
                vs_line_d = v_sync_in;
                vc_d      = v_fall ? 10'd0 : sat_inc(vc_q);
            end
        end
    end

    // Timing checks (disabled while searching) and sticky error flags.
    always_comb begin
        h_evt = 1'b0;
        v_evt = 1'b0;
        if (state_q != ST_SEARCH) begin
            h_evt = (h_fall && (hc_q != H_LAST))
                  || (h_rise && (hc_d != H_PULSE))
                  || (pix_en && !h_fall && (hc_q == H_LAST));
            v_evt = (v_fall && (vc_q != V_LAST))
                  || (v_rise && (vc_d != V_PULSE))
                  || (h_fall && !v_fall && (vc_q == V_LAST));
        end
        err_evt = h_evt || v_evt;
        // a new error wins over a simultaneous clear
        h_err_d = (h_err_q && !err_clr) || h_evt;
        v_err_d = (v_err_q && !err_clr) || v_evt;
    end

    // Lock FSM next state: count clean frames between vsync falls, drop on any error.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        case (state_q)
            ST_SEARCH: begin
                if (v_fall) begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = '0;
                end
            end
            ST_ACQUIRE: begin
                if (err_evt) begin
                    state_d = ST_SEARCH;
                end else if (v_fall) begin
                    good_cnt_d = good_cnt_q + CNT_W'(1);
                    if (good_cnt_q == LOCK_LAST) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (err_evt) begin
                    state_d = ST_SEARCH;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // Pixel capture: a locked, error-free sample inside the active window is forwarded.
    always_comb begin
        pixel_valid_d = 1'b0;
        frame_start_d = 1'b0;
        pixel_data_d  = pixel_data_q;
        x_d           = x_q;
        y_d           = y_q;
        active = (hc_d >= H_ACT_LO) && (hc_d <= H_ACT_HI)
              && (vc_d >= V_ACT_LO) && (vc_d <= V_ACT_HI);
        if (pix_en && (state_q == ST_LOCKED) && !err_evt && active) begin
            pixel_valid_d = 1'b1;
            pixel_data_d  = {red_in, green_in, blue_in};
            x_d           = hc_d - H_ACT_LO;
            y_d           = 9'(vc_d - V_ACT_LO);
            frame_start_d = (hc_d == H_ACT_LO) && (vc_d == V_ACT_LO);
        end
    end

    // State register with asynchronous reset to the search state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SEARCH;
            good_cnt_q    <= '0;
            hc_q          <= 10'h3FF;
            vc_q          <= 10'h3FF;
            hs_prev_q     <= 1'b1;
            vs_line_q     <= 1'b1;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_data_q  <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hs_prev_q     <= hs_prev_d;
            vs_line_q     <= vs_line_d;
            h_err_q       <= h_err_d;
            v_err_q       <= v_err_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_data_q  <= pixel_data_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign pixel_data  = pixel_data_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == ST_LOCKED);
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;

endmodule
